// File: rtl/imem_loader.sv
// imem_loader
//   Packs an incoming byte stream into little-endian 32-bit instruction words
//   and writes them into consecutive instruction-memory word slots, starting
//   at BASE_ADDR and stepping by 4 bytes. The CPU is held while a load runs.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   start                pulse; begins a load from IDLE or DONE
//   in_valid/in_data     byte stream, accepted when in_valid & in_ready
//   in_last              final byte of the stream (qualified by in_valid)
//   in_ready             loader can take a byte (LOAD state only)
//   imem_we              one-cycle write strobe per assembled word
//   imem_waddr           byte address of the word being written (held after)
//   imem_wdata           word being written (held after)
//   cpu_hold, busy       high while loading or writing
//   done                 level; load finished
//   error                sticky; stream ended on a partial word
//   word_count           words written in the current load
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 64,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_waddr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  state_t            state_reg, state_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       word_reg, word_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic              last_seen_reg, last_seen_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              error_reg, error_next;
  logic [31:0]       waddr_reg, waddr_next;
  logic [31:0]       wdata_reg, wdata_next;

  // Assembly word with the current input byte dropped into its lane.
  logic [31:0]       word_loaded;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_loaded[8*gi +: 8] = (byte_idx_reg == 2'(gi)) ? in_data
                                                              : word_reg[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      word_reg      <= '0;
      byte_idx_reg  <= '0;
      last_seen_reg <= 1'b0;
      count_reg     <= '0;
      error_reg     <= 1'b0;
      waddr_reg     <= '0;
      wdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      word_reg      <= word_next;
      byte_idx_reg  <= byte_idx_next;
      last_seen_reg <= last_seen_next;
      count_reg     <= count_next;
      error_reg     <= error_next;
      waddr_reg     <= waddr_next;
      wdata_reg     <= wdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    word_next      = word_reg;
    byte_idx_next  = byte_idx_reg;
    last_seen_next = last_seen_reg;
    count_next     = count_reg;
    error_next     = error_reg;
    waddr_next     = waddr_reg;
    wdata_next     = wdata_reg;
    in_ready       = 1'b0;
    imem_we        = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next     = LOAD;
          addr_next      = BASE_ADDR;
          word_next      = '0;
          byte_idx_next  = '0;
          last_seen_next = 1'b0;
          count_next     = '0;
          error_next     = 1'b0;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_next     = word_loaded;
          byte_idx_next = byte_idx_reg + 2'd1;
          if (in_last) begin
            last_seen_next = 1'b1;
            // Upper lanes of a short final word stay zero; flag it.
            if (byte_idx_reg != 2'd3) error_next = 1'b1;
          end
          if (byte_idx_reg == 2'd3 || in_last) begin
            state_next = WRITE;
            // Address/data are registered here so they are valid for the
            // whole WRITE cycle and then hold afterwards.
            waddr_next = addr_reg;
            wdata_next = word_loaded;
          end
        end
      end

      WRITE: begin
        imem_we       = 1'b1;
        addr_next     = addr_reg + 32'd4;
        count_next    = count_reg + CNT_W'(1);
        word_next     = '0;
        byte_idx_next = '0;
        if (last_seen_reg || (count_reg + CNT_W'(1)) == MAX_CNT)
          state_next = DONE;
        else
          state_next = LOAD;
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy       = (state_reg == LOAD) || (state_reg == WRITE);
  assign cpu_hold   = busy;
  assign done       = (state_reg == DONE);
  assign error      = error_reg;
  assign word_count = count_reg;
  assign imem_waddr = waddr_reg;
  assign imem_wdata = wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Two instances share the stimulus: u_dut_a uses
// the default word limit, u_dut_b uses MAX_WORDS=2. Expected writes are
// queued per instance and popped when imem_we is seen.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;

  logic        in_ready_a, imem_we_a, cpu_hold_a, busy_a, done_a, error_a;
  logic [31:0] imem_waddr_a, imem_wdata_a;
  logic [15:0] word_count_a;

  logic        in_ready_b, imem_we_b, cpu_hold_b, busy_b, done_b, error_b;
  logic [31:0] imem_waddr_b, imem_wdata_b;
  logic [15:0] word_count_b;

  always #5 clk = ~clk;

  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(64), .CNT_W(16)) u_dut_a (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_a), .imem_we(imem_we_a),
    .imem_waddr(imem_waddr_a), .imem_wdata(imem_wdata_a),
    .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a),
    .error(error_a), .word_count(word_count_a)
  );

  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(2), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_b), .imem_we(imem_we_b),
    .imem_waddr(imem_waddr_b), .imem_wdata(imem_wdata_b),
    .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b),
    .error(error_b), .word_count(word_count_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] q_a[$];
  logic [63:0] q_b[$];

  int  we_cnt_a  = 0;
  int  we_cnt_b  = 0;
  int  acc_b     = 0;
  int  hold_viol = 0;
  bit  hold_mon  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  function automatic void exp_both(input logic [31:0] addr, input logic [31:0] data);
    q_a.push_back({addr, data});
    q_b.push_back({addr, data});
  endfunction

  // Write monitors and side counters, sampled mid-cycle.
  always @(negedge clk) begin
    logic [63:0] e;
    if (imem_we_a) begin
      we_cnt_a++;
      if (q_a.size() == 0) check("a_we_unexpected", {31'd0, imem_we_a}, 32'd0);
      else begin
        e = q_a.pop_front();
        check("a_waddr", imem_waddr_a, e[63:32]);
        check("a_wdata", imem_wdata_a, e[31:0]);
        $display("a write addr=%08h data=%08h", imem_waddr_a, imem_wdata_a);
      end
    end
    if (imem_we_b) begin
      we_cnt_b++;
      if (q_b.size() == 0) check("b_we_unexpected", {31'd0, imem_we_b}, 32'd0);
      else begin
        e = q_b.pop_front();
        check("b_waddr", imem_waddr_b, e[63:32]);
        check("b_wdata", imem_wdata_b, e[31:0]);
        $display("b write addr=%08h data=%08h", imem_waddr_b, imem_wdata_b);
      end
    end
    if (in_valid && in_ready_b) acc_b++;
    if (hold_mon && !done_a && !cpu_hold_a) hold_viol++;
  end

  // All driving happens #1 after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Offer one byte; it is taken on the first edge where dut_a is ready.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready_a && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("ready_timeout", {31'd0, in_ready_a}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!done_a && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("done_timeout", {31'd0, done_a}, 32'd1);
    tick();
  endtask

  logic [7:0] t1_bytes [8];
  logic [7:0] b;
  int         base_we_a, base_we_b, base_acc;

  initial begin
    t1_bytes = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_flags", {26'd0, in_ready_a, imem_we_a, cpu_hold_a, busy_a, done_a, error_a}, 32'd0);
    check("rst_waddr", imem_waddr_a, 32'd0);
    check("rst_wdata", imem_wdata_a, 32'd0);
    check("rst_count", {16'd0, word_count_a}, 32'd0);

    // Two-word program
    exp_both(32'h0, 32'h00000513);
    exp_both(32'h4, 32'h00100593);
    pulse_start();
    check("t1_busy", {30'd0, busy_a, cpu_hold_a}, 32'd3);
    for (int i = 0; i < 8; i++) begin
      send_byte(t1_bytes[i], i == 7);
      if (i == 3) begin
        check("t1_lat_we", {31'd0, imem_we_a}, 32'd1);
        check("t1_lat_rdy_low", {31'd0, in_ready_a}, 32'd0);
        tick();
        check("t1_lat_rdy_high", {31'd0, in_ready_a}, 32'd1);
      end
    end
    wait_done();
    check("t1_done", {31'd0, done_a}, 32'd1);
    check("t1_count", {16'd0, word_count_a}, 32'd2);
    check("t1_error", {31'd0, error_a}, 32'd0);
    check("t1_q", q_a.size(), 32'd0);

    // Short final word
    exp_both(32'h0, 32'h00CCBBAA);
    pulse_start();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    wait_done();
    check("t2_done", {31'd0, done_a}, 32'd1);
    check("t2_error", {31'd0, error_a}, 32'd1);
    check("t2_count", {16'd0, word_count_a}, 32'd1);

    // start during LOAD is ignored (second word still lands at 4)
    exp_both(32'h0, 32'h04030201);
    exp_both(32'h4, 32'h44332211);
    pulse_start();
    check("t6_error_cleared", {31'd0, error_a}, 32'd0);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    pulse_start();
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    wait_done();
    check("t6_count", {16'd0, word_count_a}, 32'd2);
    check("t6_q", q_a.size() + q_b.size(), 32'd0);

    // Word limit on u_dut_b; u_dut_a keeps loading
    exp_both(32'h0, 32'h04030201);
    exp_both(32'h4, 32'h08070605);
    q_a.push_back({32'h8, 32'h0C0B0A09});
    base_we_b = we_cnt_b;
    base_acc  = acc_b;
    pulse_start();
    for (int i = 1; i <= 12; i++) begin
      b = 8'(i);
      send_byte(b, 1'b0);
      if (i == 8) check("t3_b_rdy_after8", {31'd0, in_ready_b}, 32'd0);
    end
    tick();
    tick();
    check("t3_b_writes", we_cnt_b - base_we_b, 32'd2);
    check("t3_b_accepted", acc_b - base_acc, 32'd8);
    check("t3_b_done", {31'd0, done_b}, 32'd1);
    check("t3_b_count", {16'd0, word_count_b}, 32'd2);
    check("t3_a_count", {16'd0, word_count_a}, 32'd3);
    check("t3_q", q_a.size() + q_b.size(), 32'd0);

    // Reset mid-word discards the partial word
    do_reset();
    pulse_start();
    base_we_a = we_cnt_a;
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    do_reset();
    check("t5_flags", {26'd0, in_ready_a, imem_we_a, cpu_hold_a, busy_a, done_a, error_a}, 32'd0);
    check("t5_waddr", imem_waddr_a, 32'd0);
    check("t5_wdata", imem_wdata_a, 32'd0);
    check("t5_count", {16'd0, word_count_a}, 32'd0);
    tick();
    check("t5_no_we", we_cnt_a - base_we_a, 32'd0);
    exp_both(32'h0, 32'hDDCCBBAA);
    pulse_start();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b1);
    wait_done();
    check("t5_reload_count", {16'd0, word_count_a}, 32'd1);

    // Random valid gaps on the first program
    exp_both(32'h0, 32'h00000513);
    exp_both(32'h4, 32'h00100593);
    base_we_a = we_cnt_a;
    hold_viol = 0;
    pulse_start();
    hold_mon = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_byte(t1_bytes[i], i == 7);
    end
    wait_done();
    hold_mon = 1'b0;
    check("t4_we_pulses", we_cnt_a - base_we_a, 32'd2);
    check("t4_hold", hold_viol, 32'd0);
    check("t4_done_hold", {30'd0, done_a, cpu_hold_a}, 32'd2);
    check("t4_q", q_a.size() + q_b.size(), 32'd0);

    // DONE ignores offered bytes
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    tick();
    in_valid = 1'b0;
    check("done_no_accept", {16'd0, word_count_a}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
